// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Provides the register-select type used across the datapath and the
// state encoding for the pipeline hazard/stall sequencer.
package cpu_types_pkg;

  // Register select for the 32-entry register file.
  typedef logic [4:0] regbits_t;

  // Sequencer state machine encoding.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    DMEM_WAIT = 2'b01,
    HALTED    = 2'b10
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer's debug event counters.
// Ports:
//   CLK     - clock, counts on rising edge
//   RST     - asynchronous active-high clear
//   inc_i   - increment request for this cycle
//   count_o - current count, sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: advance only while below all-ones so the value saturates.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Central hazard and stall controller for the 5-stage pipeline.
// Drives the enable/flush pair of each pipeline latch and the PC write
// enable from memory-wait, control-transfer, load-use and halt conditions.
// Ports:
//   CLK, RST                         - clock, async active-high reset
//   ihit, dhit                       - fetch / data access complete
//   dREN_mem, dWEN_mem               - MEM stage load / store
//   dREN_ex, wsel_ex                 - EX stage load and its destination
//   rs_id, rt_id, use_rs_id, use_rt_id - ID stage source registers
//   jumpFlush_ex                     - EX resolved a taken control transfer
//   halt_wb                          - halt instruction reached WB
//   pc_en, *_en, *_flush             - PC and latch controls
//   halted                           - sticky halt flag
//   stall_cnt, flush_cnt             - saturating debug counters
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = $bits(regbits_t)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             dREN_ex,
  input  logic [REG_W-1:0] wsel_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic             jumpFlush_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  seq_state_t state_q, state_d;
  logic       halted_q, halted_d;
  logic       dmemBusy;
  logic       loadUse;
  logic       stallInc;
  logic       flushInc;

  assign dmemBusy = (dREN_mem | dWEN_mem) & ~dhit;

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign loadUse = dREN_ex && (wsel_ex != '0) &&
                   ((use_rs_id && (rs_id == wsel_ex)) ||
                    (use_rt_id && (rt_id == wsel_ex)));

  // Zero-latency control decode. Reset forces every control low regardless
  // of state; otherwise the priority chain below picks the action.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    state_d      = state_q;
    halted_d     = halted_q;
    stallInc     = 1'b0;
    flushInc     = 1'b0;

    if (!RST) begin
      case (state_q)
        HALTED: begin
          ex_mem_flush = 1'b1;
          state_d      = HALTED;
        end
        default: begin
          if (dmemBusy) begin
            // Whole pipe frozen; halt_wb is not honoured until memory settles.
            state_d  = DMEM_WAIT;
            stallInc = 1'b1;
          end else begin
            state_d   = RUN;
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (jumpFlush_ex) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              flushInc    = 1'b1;
            end else if (loadUse) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end else if (!ihit) begin
              pc_en       = 1'b0;
              if_id_flush = 1'b1;
            end
            stallInc = ~pc_en;
            if (halt_wb) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and sticky halt flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .CLK     (CLK),
    .RST     (RST),
    .inc_i   (stallInc),
    .count_o (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
    .CLK     (CLK),
    .RST     (RST),
    .inc_i   (flushInc),
    .count_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a table of single-cycle
// control vectors plus hand-written multi-cycle sequences (reset during a
// memory stall, data-memory wait, branch vs. load-use, halt, saturation).
module tb_pipeline_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
  logic [4:0] wsel_ex, rs_id, rt_id;
  logic       use_rs_id, use_rt_id, jumpFlush_ex, halt_wb;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        sPc, sIfEn, sIdEn, sExEn, sMemEn, sIfFl, sIdFl, sExFl, sHalted;
  logic [3:0]  sStall, sFlush;

  logic [7:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  pipeline_sequencer #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .jumpFlush_ex(jumpFlush_ex), .halt_wb(halt_wb),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) dutSat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .dREN_ex(dREN_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .jumpFlush_ex(jumpFlush_ex), .halt_wb(halt_wb),
    .pc_en(sPc), .if_id_en(sIfEn), .id_ex_en(sIdEn),
    .ex_mem_en(sExEn), .mem_wb_en(sMemEn),
    .if_id_flush(sIfFl), .id_ex_flush(sIdFl),
    .ex_mem_flush(sExFl), .halted(sHalted),
    .stall_cnt(sStall), .flush_cnt(sFlush)
  );

  // Packed view: {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //               if_id_flush, id_ex_flush, ex_mem_flush}
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush};

  localparam logic [7:0] CTL_NORMAL = 8'b1_1111_000;
  localparam logic [7:0] CTL_NOIHIT = 8'b0_1111_100;
  localparam logic [7:0] CTL_LDUSE  = 8'b0_0111_010;
  localparam logic [7:0] CTL_JUMP   = 8'b1_1111_110;
  localparam logic [7:0] CTL_FREEZE = 8'b0_0000_000;
  localparam logic [7:0] CTL_HALTED = 8'b0_0000_001;

  typedef struct {
    string      name;
    logic       ih, dh, drm, dwm, dre;
    logic [4:0] ws, rs, rt;
    logic       urs, urt, jf;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic ih, logic dh, logic drm,
                              logic dwm, logic dre, logic [4:0] ws,
                              logic [4:0] rs, logic [4:0] rt, logic urs,
                              logic urt, logic jf, logic [7:0] exp);
    vec_t v;
    v.name = nm; v.ih = ih; v.dh = dh; v.drm = drm; v.dwm = dwm;
    v.dre = dre; v.ws = ws; v.rs = rs; v.rt = rt; v.urs = urs;
    v.urt = urt; v.jf = jf; v.exp = exp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ihit = v.ih; dhit = v.dh; dREN_mem = v.drm; dWEN_mem = v.dwm;
    dREN_ex = v.dre; wsel_ex = v.ws; rs_id = v.rs; rt_id = v.rt;
    use_rs_id = v.urs; use_rt_id = v.urt; jumpFlush_ex = v.jf;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_NORMAL));
    halt_wb = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    idleInputs();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1;
    halt_wb = 1'b0;
    idleInputs();
    #1;
    checkOutput("reset_ctl", 32'(ctl), 32'(CTL_FREEZE));
    checkOutput("reset_halted", 32'(halted), 0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 0);
    checkOutput("reset_flush_cnt", 32'(flush_cnt), 0);
    nextCycle();
    RST = 1'b0;

    // Single-cycle control vectors; order matters only for the two
    // DMEM_WAIT exit rows that follow a busy row.
    vecs.push_back(mk("normal",       1,0,0,0,0, 0, 0, 0, 0,0,0, CTL_NORMAL));
    vecs.push_back(mk("no_ihit",      0,0,0,0,0, 0, 0, 0, 0,0,0, CTL_NOIHIT));
    vecs.push_back(mk("lduse_rs",     1,0,0,0,1, 8, 8, 0, 1,0,0, CTL_LDUSE));
    vecs.push_back(mk("lduse_r0",     1,0,0,0,1, 0, 0, 0, 1,1,0, CTL_NORMAL));
    vecs.push_back(mk("lduse_rt",     1,0,0,0,1, 3, 7, 3, 0,1,0, CTL_LDUSE));
    vecs.push_back(mk("rt_unused",    1,0,0,0,1, 3, 7, 3, 1,0,0, CTL_NORMAL));
    vecs.push_back(mk("no_load",      1,0,0,0,0, 8, 8, 8, 1,1,0, CTL_NORMAL));
    vecs.push_back(mk("jump",         1,0,0,0,0, 0, 0, 0, 0,0,1, CTL_JUMP));
    vecs.push_back(mk("jump_lduse",   1,0,0,0,1, 9, 9, 0, 1,0,1, CTL_JUMP));
    vecs.push_back(mk("lduse_noihit", 0,0,0,0,1, 9, 0, 9, 0,1,0, CTL_LDUSE));
    vecs.push_back(mk("busy_jump",    1,0,1,0,0, 0, 0, 0, 0,0,1, CTL_FREEZE));
    vecs.push_back(mk("load_done",    1,1,1,0,0, 0, 0, 0, 0,0,0, CTL_NORMAL));
    vecs.push_back(mk("busy_store",   0,0,0,1,1, 4, 4, 0, 1,0,0, CTL_FREEZE));
    vecs.push_back(mk("store_noihit", 0,1,0,1,0, 0, 0, 0, 0,0,0, CTL_NOIHIT));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge CLK);
      checkOutput(vecs[i].name, 32'(ctl), 32'(vecs[i].exp));
      nextCycle();
    end

    // Reset asserted in the middle of a memory stall.
    doReset();
    ihit = 1'b1; dREN_mem = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("stall_freeze", 32'(ctl), 32'(CTL_FREEZE));
      nextCycle();
    end
    checkOutput("stall_cnt_pre_rst", 32'(stall_cnt), 3);
    RST = 1'b1; jumpFlush_ex = 1'b1;
    #1;
    checkOutput("rst_mid_ctl", 32'(ctl), 32'(CTL_FREEZE));
    checkOutput("rst_mid_stall_cnt", 32'(stall_cnt), 0);
    nextCycle();
    RST = 1'b0;
    idleInputs();
    @(negedge CLK);
    checkOutput("post_rst_ctl", 32'(ctl), 32'(CTL_NORMAL));
    checkOutput("post_rst_stall_cnt", 32'(stall_cnt), 0);
    nextCycle();

    // Store waits four cycles, completes on the fifth.
    doReset();
    dWEN_mem = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("dwait_freeze", 32'(ctl), 32'(CTL_FREEZE));
      nextCycle();
    end
    dhit = 1'b1;
    @(negedge CLK);
    checkOutput("dwait_done_ctl", 32'(ctl), 32'(CTL_NORMAL));
    checkOutput("dwait_stall_cnt", 32'(stall_cnt), 4);
    nextCycle();

    // Branch wins over load-use in the same cycle.
    doReset();
    applyStimulus(mk("jl", 1,0,0,0,1, 12, 12, 0, 1,0,1, CTL_JUMP));
    @(negedge CLK);
    checkOutput("jump_over_lduse", 32'(ctl), 32'(CTL_JUMP));
    nextCycle();
    idleInputs();
    @(negedge CLK);
    checkOutput("jump_flush_cnt", 32'(flush_cnt), 1);
    checkOutput("jump_stall_cnt", 32'(stall_cnt), 0);
    nextCycle();

    // Halt is terminal; counters frozen while halted.
    doReset();
    halt_wb = 1'b1;
    @(negedge CLK);
    checkOutput("halt_cycle_ctl", 32'(ctl), 32'(CTL_NORMAL));
    checkOutput("halt_cycle_halted", 32'(halted), 0);
    nextCycle();
    halt_wb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0];
      jumpFlush_ex = ~i[0];
      @(negedge CLK);
      checkOutput("halted_ctl", 32'(ctl), 32'(CTL_HALTED));
      checkOutput("halted_flag", 32'(halted), 1);
      nextCycle();
    end
    checkOutput("halted_flush_cnt", 32'(flush_cnt), 0);
    checkOutput("halted_stall_cnt", 32'(stall_cnt), 0);
    doReset();
    checkOutput("halt_cleared", 32'(halted), 0);

    // Saturation on the narrow-counter instance.
    doReset();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) nextCycle();
    ihit = 1'b1;
    @(negedge CLK);
    checkOutput("sat_stall_cnt4", 32'(sStall), 15);
    checkOutput("wide_stall_cnt16", 32'(stall_cnt), 20);
    nextCycle();
    jumpFlush_ex = 1'b1;
    for (int i = 0; i < 20; i++) nextCycle();
    jumpFlush_ex = 1'b0;
    @(negedge CLK);
    checkOutput("sat_flush_cnt4", 32'(sFlush), 15);
    checkOutput("wide_flush_cnt16", 32'(flush_cnt), 20);
    checkOutput("sat_stall_hold", 32'(sStall), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
